// File: rtl/sram_like_slave_ram.sv
// sram_like_slave_ram: SRAM-like responder backed by a word-organised RAM.
// Every accepted request is answered in order, exactly LATENCY cycles after
// the accepting edge. At most DEPTH requests can be outstanding at once.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   req      request valid from the initiator
//   wr       1 = write, 0 = read
//   size     0 = byte, 1 = halfword, 2 = word, 3 = illegal
//   addr     byte address; word index is addr[ADDR_WIDTH+1:2]
//   wdata    write data, already lane-positioned
//   addr_ok  request is accepted this cycle if req is high
//   data_ok  one-cycle response pulse
//   rdata    read data, forced to 0 whenever data_ok is low
//   err      sticky flag for misaligned or illegal requests
module sram_like_slave_ram #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [LATENCY-1:0]    vld_q;
    logic [31:0]           dat_q [LATENCY];
    logic                  accept;
    logic                  illegal;
    logic [3:0]            be;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           resp;
    logic                  unused_addr;

    // Upper address bits are ignored on purpose, so addresses alias.
    assign idx         = addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^addr[31:ADDR_WIDTH+2];

    // No bypass: a retiring response frees its slot only from the next cycle.
    assign addr_ok = !rst && (cnt_q < DepthC);
    assign accept  = req && addr_ok;

    always_comb begin
        illegal = 1'b0;
        be      = 4'b0000;
        case (size)
            2'd0: be = 4'b0001 << addr[1:0];
            2'd1: begin
                be      = addr[1] ? 4'b1100 : 4'b0011;
                illegal = addr[0];
            end
            2'd2: begin
                be      = 4'b1111;
                illegal = |addr[1:0];
            end
            default: illegal = 1'b1;
        endcase
    end

    // Writes and illegal requests are acknowledged with zero data.
    always_comb begin
        resp = '0;
        if (accept && !wr && !illegal) begin
            resp = mem[idx];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, data_ok})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err   <= 1'b0;
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (accept && illegal) begin
                err <= 1'b1;
            end
            vld_q[0] <= accept;
            dat_q[0] <= resp;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && wr && !illegal) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign data_ok = vld_q[LATENCY-1];
    assign rdata   = dat_q[LATENCY-1];

endmodule

// File: tb/tb_sram_like_slave_ram.sv
module tb_sram_like_slave_ram;

    localparam int ADDR_WIDTH = 12;
    localparam int LATENCY    = 2;
    localparam int DEPTH      = 2;
    localparam int WORDS      = 1 << ADDR_WIDTH;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    sram_like_slave_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LATENCY   (LATENCY),
        .DEPTH     (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .wr     (wr),
        .size   (size),
        .addr   (addr),
        .wdata  (wdata),
        .addr_ok(addr_ok),
        .data_ok(data_ok),
        .rdata  (rdata),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          retire;
        logic [31:0] data;
    } resp_t;

    // Reference model: pending responses with the edge at which each retires.
    resp_t       pend[$];
    logic [31:0] m_mem [WORDS];
    logic        m_err;
    int          edge_n;
    logic        last_acc;
    logic [31:0] resp_log[$];
    logic [31:0] burst_addr[4];

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check addr_ok before the edge, advance the model, check outputs after.
    task automatic step();
        logic        exp_aok;
        logic        acc;
        logic        ill;
        logic [3:0]  be;
        int          wi;
        logic [31:0] d;
        logic        exp_dok;
        #1;
        exp_aok = !rst && (pend.size() < DEPTH);
        chk("addr_ok", {31'b0, addr_ok}, {31'b0, exp_aok});
        acc = req && exp_aok;
        @(posedge clk);
        edge_n++;
        last_acc = acc;
        if (rst) begin
            pend.delete();
            m_err = 1'b0;
        end else begin
            while (pend.size() > 0 && pend[0].retire == edge_n) void'(pend.pop_front());
            if (acc) begin
                wi  = int'((addr / 4) % WORDS);
                ill = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
                      (size == 2'd2 && addr % 4 != 0);
                be  = (size == 2'd0) ? (4'd1 << (addr % 4)) :
                      (size == 2'd1) ? (4'd3 << (addr % 4)) : 4'hF;
                d   = 32'h0;
                if (ill) begin
                    m_err = 1'b1;
                end else if (wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) m_mem[wi][8*b +: 8] = wdata[8*b +: 8];
                    end
                end else begin
                    d = m_mem[wi];
                end
                pend.push_back('{retire: edge_n + LATENCY, data: d});
            end
        end
        #1;
        exp_dok = (pend.size() > 0) && (pend[0].retire == edge_n + 1);
        chk("data_ok", {31'b0, data_ok}, {31'b0, exp_dok});
        chk("rdata", rdata, exp_dok ? pend[0].data : 32'h0);
        chk("err", {31'b0, err}, {31'b0, m_err});
        if (data_ok) resp_log.push_back(rdata);
    endtask

    task automatic do_req(input logic w, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d);
        req   = 1'b1;
        wr    = w;
        size  = s;
        addr  = a;
        wdata = d;
        last_acc = 1'b0;
        for (int i = 0; i < 20 && !last_acc; i++) step();
        chk("accept_bound", {31'b0, last_acc}, 32'd1);
        req = 1'b0;
    endtask

    task automatic burst(input int n);
        req  = 1'b1;
        wr   = 1'b0;
        size = 2'd2;
        for (int k = 0; k < n; k++) begin
            addr     = burst_addr[k];
            last_acc = 1'b0;
            for (int i = 0; i < 20 && !last_acc; i++) step();
            chk("burst_accept_bound", {31'b0, last_acc}, 32'd1);
        end
        req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && pend.size() > 0; i++) step();
        step();
        chk("drain_bound", pend.size(), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        edge_n      = 0;
        m_err       = 1'b0;
        last_acc    = 1'b0;
        rst   = 1'b1;
        req   = 1'b0;
        wr    = 1'b0;
        size  = 2'd2;
        addr  = 32'h0;
        wdata = 32'h0;
        step();
        step();
        rst = 1'b0;
        step();

        // Word write then read.
        do_req(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 32'h100, 32'h0);
        resp_log.delete();
        drain();
        chk("word_read", resp_log[resp_log.size()-1], 32'hDEADBEEF);

        // Byte lanes.
        do_req(1'b1, 2'd2, 32'h200, 32'h0);
        do_req(1'b1, 2'd0, 32'h201, 32'h0000_1100);
        do_req(1'b1, 2'd0, 32'h203, 32'h2200_0000);
        do_req(1'b0, 2'd2, 32'h200, 32'h0);
        resp_log.delete();
        drain();
        chk("byte_read", resp_log[resp_log.size()-1], 32'h22001100);

        // Halfword lanes and a misaligned halfword.
        do_req(1'b1, 2'd2, 32'h300, 32'hFFFFFFFF);
        do_req(1'b1, 2'd1, 32'h302, 32'hABCD_0000);
        do_req(1'b0, 2'd2, 32'h300, 32'h0);
        resp_log.delete();
        drain();
        chk("half_read", resp_log[resp_log.size()-1], 32'hABCDFFFF);
        do_req(1'b1, 2'd1, 32'h301, 32'h1234_5678);
        resp_log.delete();
        drain();
        chk("illegal_resp_count", resp_log.size(), 32'd1);
        chk("illegal_rdata", resp_log[0], 32'h0);
        chk("illegal_err", {31'b0, err}, 32'd1);
        do_req(1'b0, 2'd2, 32'h300, 32'h0);
        resp_log.delete();
        drain();
        chk("half_unchanged", resp_log[resp_log.size()-1], 32'hABCDFFFF);

        // Aliasing of upper address bits.
        do_req(1'b1, 2'd2, 32'h0000_0004, 32'h5A5A5A5A);
        do_req(1'b0, 2'd2, 32'h0000_4004, 32'h0);
        resp_log.delete();
        drain();
        chk("alias_read", resp_log[resp_log.size()-1], 32'h5A5A5A5A);

        // Back-pressure: four reads with req held high.
        burst_addr[0] = 32'h100;
        burst_addr[1] = 32'h200;
        burst_addr[2] = 32'h300;
        burst_addr[3] = 32'h004;
        resp_log.delete();
        burst(4);
        drain();
        chk("burst_count", resp_log.size(), 32'd4);
        chk("burst_0", resp_log[0], 32'hDEADBEEF);
        chk("burst_1", resp_log[1], 32'h22001100);
        chk("burst_2", resp_log[2], 32'hABCDFFFF);
        chk("burst_3", resp_log[3], 32'h5A5A5A5A);

        // Reset with two reads in flight.
        burst(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        resp_log.delete();
        for (int i = 0; i < 6; i++) step();
        chk("reset_no_data_ok", resp_log.size(), 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);
        do_req(1'b0, 2'd2, 32'h100, 32'h0);
        resp_log.delete();
        drain();
        chk("reset_ram_kept", resp_log[resp_log.size()-1], 32'hDEADBEEF);

        // Random traffic over a pre-initialised window of 16 words.
        for (int w = 0; w < 16; w++) do_req(1'b1, 2'd2, 32'h800 + 32'(w * 4), $urandom);
        drain();
        for (int i = 0; i < 400; i++) begin
            req   = ($urandom_range(0, 3) != 0);
            wr    = $urandom_range(0, 1) == 1;
            size  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr  = ($urandom & 32'hFFFF_C000) | 32'h800 |
                    32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
            wdata = $urandom;
            step();
        end
        req = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_like_slave_ram.md
Name: sram_like_slave_ram

Overview:
- SRAM-like responder (slave end) backed by an internal word-organised RAM.
- Accepts requests from an SRAM-like initiator such as the inst/data ports of the SRAM-to-SRAM-like arbiter and answers with a fixed, parameterisable latency.
- Used as a bus-functional memory in CPU-level simulation.
- Also used as an on-chip scratch RAM when no AXI bridge sits behind the arbiter.

Parameters:
- ADDR_WIDTH, 12, word-address bits; capacity 2^ADDR_WIDTH words of 32 bits.
- LATENCY, 2, cycles from the accepting edge to the data_ok pulse; legal range 1..8.
- DEPTH, 2, maximum outstanding accepted-but-unanswered requests; legal range 1..LATENCY.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  1  request valid from initiator.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- addr  in  32  byte address.
- wdata  in  32  write data, already lane-positioned.
- addr_ok  out  1  request accepted this cycle when req is also high.
- data_ok  out  1  one-cycle response pulse.
- rdata  out  32  read data, valid only while data_ok = 1.
- err  out  1  sticky flag: a misaligned or illegal request was seen.

Behaviour:
- Reset values: addr_ok 0 during the reset cycle, data_ok 0, rdata 0, err 0, outstanding count 0, response pipeline cleared. RAM contents are not reset.
- Handshake: a request is accepted on a rising edge where req && addr_ok.
- addr_ok is combinational: !rst && (outstanding < DEPTH). It does not depend on req. There is no bypass when a data_ok retires in the same cycle the count is full.
- Word index: addr[ADDR_WIDTH+1:2]. Higher bits are ignored and alias.
- Write byte-enable derivation:
  - size 0: lane addr[1:0].
  - size 1: lanes {addr[1],0} and {addr[1],1}; addr[0] must be 0.
  - size 2: all four lanes; addr[1:0] must be 0.
- Only enabled lanes of wdata are written, at the accepting edge.
- Illegal request (size 3, or misaligned for its size):
  - no RAM write;
  - err set, and it holds until rst;
  - the request is still accepted and answered with rdata 0.
- Read:
  - full 32-bit word sampled at the accepting edge, with size ignored for reads apart from the legality check;
  - a read accepted the cycle after a write to the same word returns the new data.
- Response pipeline: a shift register of LATENCY stages carrying {valid, data}. Stage 0 is loaded at acceptance; data_ok/rdata are driven from the last stage, registered.
  - LATENCY = 1: data_ok in the cycle after the accepting edge.
  - LATENCY = N: data_ok N cycles after the accepting edge.
- Responses are strictly in order, with exactly one data_ok per accepted request. Back-to-back accepts give back-to-back data_ok pulses.
- rdata is 0 whenever data_ok = 0.
- Outstanding counter:
  - increments on accept, decrements on data_ok;
  - when both happen in the same cycle it is unchanged;
  - never exceeds DEPTH and never underflows.
- Reset mid-operation: all in-flight responses are dropped, no data_ok is issued for them, and writes already performed stay in RAM.
- The initiator may change addr, wdata or size while addr_ok = 0; only values sampled at the accepting edge matter.

Test Plan:
- LATENCY=2, write word 0xDEADBEEF @0x100, then read @0x100:
  - addr_ok high on both requests;
  - data_ok pulses two cycles after each accept;
  - read rdata = 0xDEADBEEF.
- Byte writes 0x11@0x201, 0x22@0x203 over word 0x00000000, then word read @0x200 -> rdata 0x22001100.
- Halfword 0xABCD@0x302 over 0xFFFFFFFF, then read -> 0xABCDFFFF. Halfword @0x301 -> err = 1, data_ok still issued, rdata 0, word 0x300 unchanged.
- DEPTH=2, req held high with 4 reads:
  - addr_ok drops after 2 accepts;
  - it returns high in the cycle after the first data_ok;
  - 4 data_ok pulses arrive in order with the correct words;
  - the count never exceeds 2.
- Assert rst one cycle after 2 reads are accepted -> no data_ok follows; err = 0, count = 0; previously written RAM data still readable.
- Address aliasing: write 0x5A5A5A5A @0x0000_0004, read @0x0000_4004 with ADDR_WIDTH=12 -> rdata 0x5A5A5A5A.
